melody_sequencer: RTL and testbench

- Plays a melody stored in an external synchronous note ROM by sequencing the square-wave tone generator.
- Fetches one 8-bit note entry per step, converts the note code to a half-period count and holds it for the encoded duration.
- Inserts a silent articulation gap between notes; supports start, stop and looped playback.
- Sits between the board clock (12 MHz) and the tone generator that drives the speaker.

---
 rtl/musicbox_pkg.sv | 71 +++++++
 rtl/melody_sequencer_if.sv | 28 ++
 rtl/melody_sequencer_timer.sv | 64 ++++++
 rtl/melody_sequencer.sv | 158 +++++++++++++++
 tb/tb_melody_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/musicbox_pkg.sv
// Shared constants, state encoding and pitch helpers for the melody sequencer.
// Note frequencies are integer Hz so the derived half periods are exact truncations.
package musicbox_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_CS4  = 4'd2;
  localparam logic [3:0] NOTE_D4   = 4'd3;
  localparam logic [3:0] NOTE_DS4  = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_F4   = 4'd6;
  localparam logic [3:0] NOTE_FS4  = 4'd7;
  localparam logic [3:0] NOTE_G4   = 4'd8;
  localparam logic [3:0] NOTE_GS4  = 4'd9;
  localparam logic [3:0] NOTE_A4   = 4'd10;
  localparam logic [3:0] NOTE_AS4  = 4'd11;
  localparam logic [3:0] NOTE_B4   = 4'd12;
  localparam logic [3:0] NOTE_C5   = 4'd13;
  localparam logic [3:0] NOTE_RSVD = 4'd14;
  localparam logic [3:0] NOTE_END  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned note_freq_hz(input logic [3:0] code);
    int unsigned f;
    case (code)
      NOTE_C4:  f = 262;
      NOTE_CS4: f = 277;
      NOTE_D4:  f = 294;
      NOTE_DS4: f = 311;
      NOTE_E4:  f = 330;
      NOTE_F4:  f = 349;
      NOTE_FS4: f = 370;
      NOTE_G4:  f = 392;
      NOTE_GS4: f = 415;
      NOTE_A4:  f = 440;
      NOTE_AS4: f = 466;
      NOTE_B4:  f = 494;
      NOTE_C5:  f = 523;
      NOTE_REST, NOTE_RSVD, NOTE_END: f = 0;
      default:  f = 0;
    endcase
    return f;
  endfunction

  function automatic logic [15:0] note_half_period(input logic [3:0] code,
                                                   input int unsigned clk_hz);
    int unsigned f;
    f = note_freq_hz(code);
    if (f == 0) return 16'd0;
    return 16'(clk_hz / (2 * f));
  endfunction

  function automatic logic is_pitched(input logic [3:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_C5);
  endfunction

  function automatic int cnt_width(input int unsigned v);
    int w;
    w = $clog2(v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Note ROM read port and tone generator drive, bundled for the sequencer.
interface melody_sequencer_if #(
  parameter int ADDR_W = 6
);
  // No backpressure: rom_data is valid the cycle after rom_addr is held (registered
  // ROM), and note_strobe is a one-cycle "valid" marking a new tone_half_period/tone_en.
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [15:0]       tone_half_period;
  logic              tone_en;
  logic              note_strobe;

  modport master (
    output rom_addr,
    output tone_half_period,
    output tone_en,
    output note_strobe,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  tone_half_period,
    input  tone_en,
    input  note_strobe,
    output rom_data
  );
endinterface

// File: rtl/melody_sequencer_timer.sv
// seq_duration_timer: prescaler of unit_len_i cycles feeding a 4-bit unit counter.
// After load it raises expire_o in the last of (units_i+1)*unit_len_i cycles.
module seq_duration_timer #(
  parameter int UNIT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [UNIT_W-1:0] unit_len_i,
  input  logic [3:0]        units_i,
  output logic              expire_o
);

  logic              active_q, active_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [UNIT_W-1:0] pre_q, pre_d;
  logic [3:0]        cnt_q, cnt_d;

  assign expire_o = active_q && (pre_q == '0) && (cnt_q == '0);

  always_comb begin
    active_d = active_q;
    unit_d   = unit_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      active_d = 1'b0;
      unit_d   = '0;
      pre_d    = '0;
      cnt_d    = '0;
    end else if (load_i) begin
      // A zero-length unit still lasts one cycle so the counter always terminates.
      active_d = 1'b1;
      unit_d   = unit_len_i;
      pre_d    = (unit_len_i == '0) ? '0 : unit_len_i - UNIT_W'(1);
      cnt_d    = units_i;
    end else if (active_q) begin
      if (pre_q != '0) begin
        pre_d = pre_q - UNIT_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
        pre_d = (unit_q == '0) ? '0 : unit_q - UNIT_W'(1);
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      unit_q   <= '0;
      pre_q    <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      unit_q   <= unit_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a note ROM, driving a square-wave tone generator with timed notes and gaps.
// Optional macro SEQ_TEMPO_EN adds tempo_shift to shorten the duration unit by 1x/2x/4x/8x.
module melody_sequencer
  import musicbox_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DUR_UNIT   = 750000,
  parameter int unsigned GAP_CYCLES = 120000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
`ifdef SEQ_TEMPO_EN
  input  logic [1:0]         tempo_shift,
`endif
  output logic               busy,
  output logic               done,
  output seq_state_e         dbg_state,
  melody_sequencer_if.master bus
);

  localparam int UNIT_W = cnt_width((DUR_UNIT > GAP_CYCLES) ? DUR_UNIT : GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       hp_q, hp_d;
  logic              tone_en_q, tone_en_d;
  logic              strobe_q, strobe_d;

  logic              tmr_clear, tmr_load, tmr_expire;
  logic [UNIT_W-1:0] tmr_unit;
  logic [3:0]        tmr_units;
  logic [UNIT_W-1:0] dur_unit;

  logic [3:0]        code, dcode;
  logic [15:0]       hp_table [16];
  logic [ADDR_W-1:0] next_addr;
  seq_state_e        adv_state;

  assign code  = bus.rom_data[7:4];
  assign dcode = bus.rom_data[3:0];

  // Half periods are elaboration-time constants; no divider is built.
  for (genvar g = 0; g < 16; g++) begin : g_hp
    assign hp_table[g] = note_half_period(4'(g), CLK_HZ);
  end

`ifdef SEQ_TEMPO_EN
  assign dur_unit = UNIT_W'(DUR_UNIT) >> tempo_shift;
`else
  assign dur_unit = UNIT_W'(DUR_UNIT);
`endif

  // Stepping past the last ROM slot behaves like an END entry.
  assign next_addr = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
  assign adv_state = ((addr_q == ADDR_LAST) && !loop_en) ? ST_DONE : ST_FETCH;

  seq_duration_timer #(.UNIT_W(UNIT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .unit_len_i (tmr_unit),
    .units_i    (tmr_units),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hp_d      = hp_q;
    tone_en_d = tone_en_q;
    strobe_d  = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_unit  = dur_unit;
    tmr_units = dcode;
    if (stop) begin
      state_d   = ST_IDLE;
      addr_d    = '0;
      tone_en_d = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          if (code == NOTE_END) begin
            addr_d  = '0;
            state_d = loop_en ? ST_FETCH : ST_DONE;
          end else begin
            if (is_pitched(code)) hp_d = hp_table[code];
            tone_en_d = is_pitched(code);
            strobe_d  = 1'b1;
            tmr_load  = 1'b1;
            state_d   = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tmr_expire) begin
            tone_en_d = 1'b0;
            if (GAP_CYCLES > 0) begin
              tmr_load  = 1'b1;
              tmr_unit  = UNIT_W'(GAP_CYCLES);
              tmr_units = '0;
              state_d   = ST_GAP;
            end else begin
              addr_d  = next_addr;
              state_d = adv_state;
            end
          end
        end
        ST_GAP: begin
          if (tmr_expire) begin
            addr_d  = next_addr;
            state_d = adv_state;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      hp_q      <= '0;
      tone_en_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hp_q      <= hp_d;
      tone_en_q <= tone_en_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.rom_addr         = addr_q;
  assign bus.tone_half_period = hp_q;
  assign bus.tone_en          = tone_en_q;
  assign bus.note_strobe      = strobe_q;
  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_DONE);
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboarded bench for melody_sequencer: a ROM-walking reference model queues expected
// notes, a negedge monitor measures each played note and compares.
module tb_melody_sequencer;
  import musicbox_pkg::*;

  localparam int DUR   = 4;
  localparam int GAP   = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop_en;
  logic [1:0] tempo_shift;
  logic       busy, done;
  seq_state_e dbg_state;

  logic [7:0]  rom [DEPTH];
  logic [24:0] exp_q [$];
  logic [15:0] model_hp = 16'd0;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int note_cnt = 0;
  bit chk_en   = 1'b0;
  bit mon_busy = 1'b0;

  melody_sequencer_if #(.ADDR_W(AW)) bus ();

  melody_sequencer #(
    .CLK_HZ(12000000), .ADDR_W(AW), .DUR_UNIT(DUR), .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
`ifdef SEQ_TEMPO_EN
    .tempo_shift (tempo_shift),
`endif
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_hp(input logic [3:0] code);
    int freq [14];
    freq = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523};
    return 16'(12000000 / (2 * freq[int'(code)]));
  endfunction

  // Walk the ROM the way a listener would hear it: one entry per note, END or wrap ends a pass.
  task automatic model_play(input bit lp, input int passes);
    int a, p;
    logic [3:0] code, d;
    logic en;
    logic [7:0] dur;
    a = 0;
    p = 0;
    while (p < passes) begin
      code = rom[a][7:4];
      d    = rom[a][3:0];
      if (code == 4'd15) begin
        p++;
        a = 0;
        if (!lp) return;
      end else begin
        en = (code >= 4'd1) && (code <= 4'd13);
        if (en) model_hp = ref_hp(code);
        dur = 8'((int'(d) + 1) * (DUR >> tempo_shift));
        exp_q.push_back({en, model_hp, dur});
        if (a == DEPTH - 1) begin
          a = 0;
          p++;
          if (!lp) return;
        end else begin
          a++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_seq(input bit lp, input int passes, input bit chk_lat);
    int d0, n, k;
    model_play(lp, passes);
    d0 = done_cnt;
    loop_en = lp;
    pulse_start();
    if (chk_lat) begin
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        if (bus.note_strobe) break;
        n++;
      end
      check("start_latency", n, 2);
    end
    k = 0;
    if (lp) begin
      while ((exp_q.size() != 0 || mon_busy) && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("loop_in_time", 32'(k < 3000), 1);
      check("loop_no_done", done_cnt - d0, 0);
      check("loop_busy", busy, 1);
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      check("loop_stop_busy", busy, 0);
    end else begin
      while (busy && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("run_in_time", 32'(k < 3000), 1);
      check("done_count", done_cnt - d0, 1);
    end
    check("queue_drained", exp_q.size(), 0);
    check("addr_idle", 32'(bus.rom_addr), 0);
    check("tone_idle", bus.tone_en, 0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [24:0] e;
    logic        got_en;
    logic [15:0] got_hp;
    int play, high, strb;
    forever begin
      @(negedge clk);
      if (bus.note_strobe && chk_en) begin
        mon_busy = 1'b1;
        got_en = bus.tone_en;
        got_hp = bus.tone_half_period;
        play = 0;
        high = 0;
        strb = 0;
        while (dbg_state == ST_PLAY && play < 300) begin
          play++;
          if (bus.tone_en) high++;
          if (bus.note_strobe) strb++;
          @(negedge clk);
        end
        note_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_note: got hp %0d en %0d, expected no note", got_hp, got_en);
        end else begin
          e = exp_q.pop_front();
          check("note_en", got_en, e[24]);
          check("note_hp", got_hp, e[23:8]);
          check("note_cycles", play, e[7:0]);
          check("tone_high_cycles", high, e[24] ? e[7:0] : 0);
          check("strobe_width", strb, 1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, n0, k;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    tempo_shift = 2'd0;
    foreach (rom[i]) rom[i] = 8'hF0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tone_en", bus.tone_en, 0);
    check("reset_hp", bus.tone_half_period, 0);
    check("reset_strobe", bus.note_strobe, 0);
    check("reset_addr", 32'(bus.rom_addr), 0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    chk_en = 1'b1;

    // single C4 note, with start latency
    rom = '{8'h11, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seq(1'b0, 1, 1'b1);

    // rest then A4
    rom = '{8'h00, 8'hA2, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n0 = note_cnt;
    run_seq(1'b0, 1, 1'b0);
    check("notes_played", note_cnt - n0, 2);

    // same ROM looping over three passes
    run_seq(1'b1, 3, 1'b0);

    // full ROM without END: implicit END at wrap
    foreach (rom[i]) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3))};
    run_seq(1'b0, 1, 1'b0);

    // random melodies, END may appear anywhere
    repeat (6) begin
      foreach (rom[i]) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
      run_seq(1'b0, 1, 1'b0);
    end

    // random looping melody
    foreach (rom[i]) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
    rom[0] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3))};
    run_seq(1'b1, 2, 1'b0);

`ifdef SEQ_TEMPO_EN
    tempo_shift = 2'd1;
    rom = '{8'h11, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seq(1'b0, 1, 1'b0);
    tempo_shift = 2'd0;
`endif

    // stop mid-note
    chk_en = 1'b0;
    rom = '{8'h1F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    loop_en = 1'b0;
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (dbg_state != ST_PLAY && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check("stop_pre_tone", bus.tone_en, 1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    check("stop_tone_en", bus.tone_en, 0);
    check("stop_busy", busy, 0);
    check("stop_addr", 32'(bus.rom_addr), 0);
    stop = 1'b0;
    repeat (5) @(negedge clk);
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_stays_idle", busy, 0);
    model_hp = ref_hp(4'd1);

    // start and stop together
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    check("start_stop_busy", busy, 0);
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check("start_stop_idle", busy, 0);

    // asynchronous reset mid-note
    pulse_start();
    k = 0;
    while (dbg_state != ST_PLAY && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_tone_en", bus.tone_en, 0);
    check("rst_hp", bus.tone_half_period, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_strobe", bus.note_strobe, 0);
    @(negedge clk) rst = 1'b0;
    model_hp = 16'd0;
    chk_en = 1'b1;

    // rest straight after reset keeps the cleared half period
    rom = '{8'h03, 8'h51, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seq(1'b0, 1, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
